// File: rtl/mandelbrot_scheduler.sv
// Frame scheduler: scans a pixel grid, dispatches c values to NCORES engines and streams (x,y,count) results.
// Optional SCHED_PERF_EN adds a saturating busy-cycle counter output perf_cycles.
module mandelbrot_scheduler #(
  parameter int NCORES = 4,
  parameter int Q      = 12,
  parameter int N      = 16,
  parameter int NC     = 8,
  parameter int XW     = 8,
  parameter int YW     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [N-1:0]         cfg_x0,
  input  logic [N-1:0]         cfg_y0,
  input  logic [N-1:0]         cfg_dx,
  input  logic [N-1:0]         cfg_dy,
  input  logic [XW-1:0]        cfg_width,
  input  logic [YW-1:0]        cfg_height,
  output logic                 busy,
  output logic                 frame_done,
  output logic [NCORES-1:0]    core_run,
  input  logic [NCORES-1:0]    core_done,
  input  logic [NCORES*NC-1:0] core_count,
  output logic [NCORES*N-1:0]  core_c_re,
  output logic [NCORES*N-1:0]  core_c_im,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [XW-1:0]        res_x,
  output logic [YW-1:0]        res_y,
  output logic [NC-1:0]        res_count
`ifdef SCHED_PERF_EN
  ,
  output logic [31:0]          perf_cycles
`endif
);

  localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;

  if (NCORES < 1 || NCORES > 8 || Q < 1 || Q >= N) begin : g_bad_param
    $error("mandelbrot_scheduler: NCORES must be 1..8 and Q must be 1..N-1");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN} top_st_t;
  typedef enum logic [2:0] {SL_FREE, SL_LAUNCH, SL_WAIT_LO, SL_WAIT_HI, SL_RESULT} slot_st_t;

  top_st_t  st, st_nx;
  slot_st_t slot_st [NCORES];
  slot_st_t slot_nx [NCORES];

  logic [N-1:0]  x0_q, dx_q, dy_q;
  logic [XW-1:0] w_q;
  logic [YW-1:0] h_q;
  logic [N-1:0]  acc_re, acc_im;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;

  logic [XW-1:0] slot_x   [NCORES];
  logic [YW-1:0] slot_y   [NCORES];
  logic [NC-1:0] slot_cnt [NCORES];
  logic [N-1:0]  c_re_q   [NCORES];
  logic [N-1:0]  c_im_q   [NCORES];

  logic [IW-1:0] res_slot, rr_ptr;
  logic          start_acc, launch, last_pix, accept, others_free;
  logic          disp_found, gnt_found;
  logic [IW-1:0] disp_idx, gnt_idx;

  // Engine format is sign-magnitude; the most negative value has no magnitude and saturates.
  function automatic logic [N-1:0] to_sm(input logic [N-1:0] v);
    logic [N-1:0] neg;
    neg = (~v) + {{(N-1){1'b0}}, 1'b1};
    if (!v[N-1])
      to_sm = v;
    else if (v == {1'b1, {(N-1){1'b0}}})
      to_sm = {N{1'b1}};
    else
      to_sm = {1'b1, neg[N-2:0]};
  endfunction

  assign start_acc = (st == ST_IDLE) && start;
  assign last_pix  = (pix_x == w_q) && (pix_y == h_q);
  assign accept    = res_valid && res_ready;
  assign launch    = (st == ST_SCAN) && disp_found;
  assign busy      = (st != ST_IDLE);

  // An engine whose done is still low (in flight across a reset) is never picked.
  always_comb begin
    disp_found = 1'b0;
    disp_idx   = '0;
    for (int i = NCORES - 1; i >= 0; i--) begin
      if (slot_st[i] == SL_FREE && core_done[i]) begin
        disp_found = 1'b1;
        disp_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NCORES; k++) begin
      if (!gnt_found && slot_st[(int'(rr_ptr) + k) % NCORES] == SL_RESULT) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'((int'(rr_ptr) + k) % NCORES);
      end
    end
  end

  always_comb begin
    others_free = 1'b1;
    for (int i = 0; i < NCORES; i++) begin
      if (slot_st[i] != SL_FREE && IW'(i) != res_slot)
        others_free = 1'b0;
    end
  end

  always_comb begin
    st_nx      = st;
    frame_done = 1'b0;
    case (st)
      ST_IDLE:  if (start) st_nx = ST_SCAN;
      ST_SCAN:  if (launch && last_pix) st_nx = ST_DRAIN;
      ST_DRAIN: begin
        if (accept && others_free) begin
          st_nx      = ST_IDLE;
          frame_done = 1'b1;
        end
      end
      default:  st_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NCORES; i++) begin
      slot_nx[i] = slot_st[i];
      case (slot_st[i])
        SL_FREE:    if (launch && disp_idx == IW'(i)) slot_nx[i] = SL_LAUNCH;
        SL_LAUNCH:  slot_nx[i] = SL_WAIT_LO;
        SL_WAIT_LO: if (!core_done[i]) slot_nx[i] = SL_WAIT_HI;
        SL_WAIT_HI: if (core_done[i]) slot_nx[i] = SL_RESULT;
        SL_RESULT:  if (accept && res_slot == IW'(i)) slot_nx[i] = SL_FREE;
        default:    slot_nx[i] = SL_FREE;
      endcase
    end
  end

  always_comb begin
    core_run  = '0;
    core_c_re = '0;
    core_c_im = '0;
    for (int i = 0; i < NCORES; i++) begin
      core_run[i]        = (slot_st[i] == SL_LAUNCH);
      core_c_re[i*N +: N] = c_re_q[i];
      core_c_im[i*N +: N] = c_im_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= ST_IDLE;
      for (int i = 0; i < NCORES; i++) slot_st[i] <= SL_FREE;
    end else begin
      st <= st_nx;
      for (int i = 0; i < NCORES; i++) slot_st[i] <= slot_nx[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x0_q   <= '0;
      dx_q   <= '0;
      dy_q   <= '0;
      w_q    <= '0;
      h_q    <= '0;
      acc_re <= '0;
      acc_im <= '0;
      pix_x  <= '0;
      pix_y  <= '0;
      for (int i = 0; i < NCORES; i++) begin
        slot_x[i]   <= '0;
        slot_y[i]   <= '0;
        slot_cnt[i] <= '0;
        c_re_q[i]   <= '0;
        c_im_q[i]   <= '0;
      end
    end else begin
      if (start_acc) begin
        x0_q   <= cfg_x0;
        dx_q   <= cfg_dx;
        dy_q   <= cfg_dy;
        w_q    <= cfg_width;
        h_q    <= cfg_height;
        acc_re <= cfg_x0;
        acc_im <= cfg_y0;
        pix_x  <= '0;
        pix_y  <= '0;
      end else if (launch) begin
        if (pix_x == w_q) begin
          pix_x  <= '0;
          pix_y  <= pix_y + 1'b1;
          acc_re <= x0_q;
          acc_im <= acc_im + dy_q;
        end else begin
          pix_x  <= pix_x + 1'b1;
          acc_re <= acc_re + dx_q;
        end
      end
      for (int i = 0; i < NCORES; i++) begin
        if (launch && disp_idx == IW'(i)) begin
          slot_x[i] <= pix_x;
          slot_y[i] <= pix_y;
          c_re_q[i] <= to_sm(acc_re);
          c_im_q[i] <= to_sm(acc_im);
        end
        if (slot_st[i] == SL_WAIT_HI && core_done[i])
          slot_cnt[i] <= core_count[i*NC +: NC];
      end
    end
  end

  // The granted slot stays in RESULT until its result is accepted; a new grant waits for an empty register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_x     <= '0;
      res_y     <= '0;
      res_count <= '0;
      res_slot  <= '0;
      rr_ptr    <= '0;
    end else if (res_valid) begin
      if (res_ready) begin
        res_valid <= 1'b0;
        rr_ptr    <= (res_slot == IW'(NCORES - 1)) ? '0 : res_slot + 1'b1;
      end
    end else if (gnt_found) begin
      res_valid <= 1'b1;
      res_x     <= slot_x[gnt_idx];
      res_y     <= slot_y[gnt_idx];
      res_count <= slot_cnt[gnt_idx];
      res_slot  <= gnt_idx;
    end
  end

`ifdef SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      perf_cycles <= '0;
    else if (start_acc)
      perf_cycles <= '0;
    else if (busy && perf_cycles != 32'hFFFF_FFFF)
      perf_cycles <= perf_cycles + 32'd1;
  end
`endif

endmodule
